// File: rtl/tpc_pkg.sv
// Shared definitions for the TPC program loader: opcodes, completion codes
// and loader FSM states.
package tpc_pkg;

  localparam logic [7:0] OP_TENSOR = 8'h01;
  localparam logic [7:0] OP_VECTOR = 8'h02;
  localparam logic [7:0] OP_SYNC   = 8'h04;
  localparam logic [7:0] OP_HALT   = 8'hFF;

  typedef enum logic [2:0] {
    ERR_OK            = 3'd0,
    ERR_TPC_ERROR     = 3'd1,
    ERR_TIMEOUT       = 3'd2,
    ERR_NO_HALT       = 3'd3,
    ERR_IMEM_OVERFLOW = 3'd4
  } err_code_e;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LOAD,
    LD_DRAIN,
    LD_START,
    LD_RUN,
    LD_DONE
  } loader_state_e;

endpackage

// File: rtl/tpc_loader_skid.sv
// One-entry valid/ready output register; a new word may enter in the same
// cycle the held word is consumed.
module tpc_loader_skid #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_addr <= in_addr;
      end
    end
  end

endmodule

// File: rtl/tpc_program_loader.sv
// Streams a host program into TPC instruction memory over the NoC receive
// port, launches the TPC at the load base and supervises completion.
module tpc_program_loader
  import tpc_pkg::*;
#(
  parameter int unsigned SRAM_WIDTH     = 256,
  parameter int unsigned INSTR_WIDTH    = 128,
  parameter int unsigned IMEM_DEPTH     = 256,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   go,
  input  logic                   load_en,
  input  logic [19:0]            base_pc,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [INSTR_WIDTH-1:0] s_data,
  input  logic                   s_last,
  output logic [SRAM_WIDTH-1:0]  noc_rx_data,
  output logic [19:0]            noc_rx_addr,
  output logic                   noc_rx_valid,
  input  logic                   noc_rx_ready,
  output logic                   noc_rx_is_instr,
  output logic                   tpc_start,
  output logic [19:0]            tpc_start_pc,
  input  logic                   tpc_busy,
  input  logic                   tpc_done,
  input  logic                   tpc_error,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             err_code,
  output logic [CNT_W-1:0]       instr_count,
  output logic [CNT_W-1:0]       run_cycles
);

  localparam int unsigned PC_W = 20;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  loader_state_e state, state_next;
  err_code_e     err_q, err_next;

  logic [PC_W-1:0]        base_q;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       cycles_q;
  logic                   last_q;
  logic                   halt_q;
  logic                   start_q;
  logic                   accept;
  logic                   push;
  logic                   skid_ready;
  logic                   buf_valid;
  logic                   buf_empty_next;
  logic                   ovf;
  logic [PC_W:0]          wr_addr_wide;
  logic [INSTR_WIDTH-1:0] buf_data;
  logic [PC_W-1:0]        buf_addr;
  logic                   unused_inputs;

  assign unused_inputs = tpc_busy;

  // One extra address bit so a base near the top of the PC space cannot wrap
  // back into range.
  assign wr_addr_wide = {1'b0, base_q} + (PC_W+1)'(count_q);
  assign ovf          = wr_addr_wide >= (PC_W+1)'(IMEM_DEPTH);

  assign accept         = s_valid && s_ready;
  assign push           = accept && (state == LD_LOAD) && !ovf;
  assign buf_empty_next = !buf_valid || noc_rx_ready;

  tpc_loader_skid #(
    .DATA_W (INSTR_WIDTH),
    .ADDR_W (PC_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (push),
    .in_ready  (skid_ready),
    .in_data   (s_data),
    .in_addr   (wr_addr_wide[PC_W-1:0]),
    .out_valid (buf_valid),
    .out_ready (noc_rx_ready),
    .out_data  (buf_data),
    .out_addr  (buf_addr)
  );

  always_comb begin
    state_next = state;
    err_next   = err_q;
    s_ready    = 1'b0;
    unique case (state)
      LD_IDLE: begin
        if (go) begin
          state_next = load_en ? LD_LOAD : LD_START;
          err_next   = ERR_OK;
        end
      end
      LD_LOAD: begin
        s_ready = !last_q && skid_ready;
        if (s_valid && s_ready && ovf) begin
          state_next = LD_DRAIN;
          err_next   = ERR_IMEM_OVERFLOW;
        end else if (last_q && buf_empty_next) begin
          if (halt_q) begin
            state_next = LD_START;
          end else begin
            state_next = LD_DONE;
            err_next   = ERR_NO_HALT;
          end
        end
      end
      LD_DRAIN: begin
        // Words already in the output register still complete their write.
        s_ready = !last_q;
        if (last_q && buf_empty_next) state_next = LD_DONE;
      end
      LD_START: begin
        if (start_q) state_next = LD_RUN;
      end
      LD_RUN: begin
        if (tpc_error) begin
          state_next = LD_DONE;
          err_next   = ERR_TPC_ERROR;
        end else if (tpc_done) begin
          state_next = LD_DONE;
          err_next   = ERR_OK;
        end else if (cycles_q == TMO_LAST) begin
          state_next = LD_DONE;
          err_next   = ERR_TIMEOUT;
        end
      end
      LD_DONE: state_next = LD_IDLE;
      default: state_next = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LD_IDLE;
      err_q    <= ERR_OK;
      base_q   <= '0;
      count_q  <= '0;
      cycles_q <= '0;
      last_q   <= 1'b0;
      halt_q   <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state   <= state_next;
      err_q   <= err_next;
      start_q <= (state == LD_START) && !start_q;
      if (state == LD_IDLE && go) begin
        base_q   <= base_pc;
        count_q  <= '0;
        cycles_q <= '0;
        last_q   <= 1'b0;
        halt_q   <= 1'b0;
      end
      if (accept) begin
        if (count_q != '1) count_q <= count_q + CNT_W'(1);
        if (s_last) begin
          last_q <= 1'b1;
          halt_q <= (s_data[INSTR_WIDTH-1 -: 8] == OP_HALT);
        end
      end
      if (state == LD_RUN && cycles_q != '1) cycles_q <= cycles_q + CNT_W'(1);
    end
  end

  always_comb begin
    noc_rx_data                  = '0;
    noc_rx_data[INSTR_WIDTH-1:0] = buf_data;
  end

  assign noc_rx_addr     = buf_addr;
  assign noc_rx_valid    = buf_valid;
  assign noc_rx_is_instr = buf_valid;
  assign tpc_start       = (state == LD_START);
  assign tpc_start_pc    = tpc_start ? base_q : '0;
  assign busy            = (state != LD_IDLE);
  assign done            = (state == LD_DONE);
  assign err_code        = err_q;
  assign instr_count     = count_q;
  assign run_cycles      = cycles_q;

endmodule

// File: tb/tb_tpc_program_loader.sv
// Directed bench for tpc_program_loader: load/launch, back-pressure,
// NO_HALT, overflow, timeout, reset and error-priority cases.
module tb_tpc_program_loader;
  import tpc_pkg::*;

  logic         clk = 1'b0;
  logic         rst, go, load_en, s_valid, s_last;
  logic [19:0]  base_pc;
  logic [127:0] s_data;
  logic         s_ready;
  logic [255:0] noc_rx_data;
  logic [19:0]  noc_rx_addr, tpc_start_pc;
  logic         noc_rx_valid, noc_rx_ready, noc_rx_is_instr, tpc_start;
  logic         tpc_busy, tpc_done, tpc_error, busy, done;
  logic [2:0]   err_code;
  logic [15:0]  instr_count, run_cycles;

  int n_checks = 0;
  int n_errors = 0;
  bit toggle_ready = 1'b0;

  logic [127:0] prog [0:15];
  logic [19:0]  wa [$];
  logic [127:0] wd [$];
  int           start_cnt, done_cnt, fmt_err, stable_err;
  logic         prev_stall;
  logic [19:0]  prev_addr;
  logic [255:0] prev_data;

  always #5 clk = ~clk;

  tpc_program_loader #(
    .SRAM_WIDTH     (256),
    .INSTR_WIDTH    (128),
    .IMEM_DEPTH     (256),
    .TIMEOUT_CYCLES (64),
    .CNT_W          (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .go              (go),
    .load_en         (load_en),
    .base_pc         (base_pc),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .s_last          (s_last),
    .noc_rx_data     (noc_rx_data),
    .noc_rx_addr     (noc_rx_addr),
    .noc_rx_valid    (noc_rx_valid),
    .noc_rx_ready    (noc_rx_ready),
    .noc_rx_is_instr (noc_rx_is_instr),
    .tpc_start       (tpc_start),
    .tpc_start_pc    (tpc_start_pc),
    .tpc_busy        (tpc_busy),
    .tpc_done        (tpc_done),
    .tpc_error       (tpc_error),
    .busy            (busy),
    .done            (done),
    .err_code        (err_code),
    .instr_count     (instr_count),
    .run_cycles      (run_cycles)
  );

  // Observe NoC writes, launch strobes and done pulses at each active edge.
  always @(posedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (noc_rx_valid && noc_rx_ready) begin
        wa.push_back(noc_rx_addr);
        wd.push_back(noc_rx_data[127:0]);
      end
      if (noc_rx_valid && (!noc_rx_is_instr || noc_rx_data[255:128] != '0)) fmt_err++;
      if (prev_stall && (noc_rx_valid !== 1'b1 || noc_rx_addr !== prev_addr ||
                         noc_rx_data !== prev_data)) stable_err++;
      prev_stall = noc_rx_valid && !noc_rx_ready;
      prev_addr  = noc_rx_addr;
      prev_data  = noc_rx_data;
      if (tpc_start) start_cnt++;
      if (done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_ready) noc_rx_ready = ~noc_rx_ready;
  endtask

  task automatic clear_mon();
    wa.delete();
    wd.delete();
    start_cnt  = 0;
    done_cnt   = 0;
    fmt_err    = 0;
    stable_err = 0;
  endtask

  function automatic logic probe(input int sel);
    return (sel == 0) ? tpc_start : done;
  endfunction

  task automatic wait_for(input string tag, input int sel, input logic level, input int budget);
    int n = 0;
    while (probe(sel) !== level && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(probe(sel)), 64'(level));
  endtask

  function automatic logic outs_any();
    return s_ready | noc_rx_valid | noc_rx_is_instr | tpc_start | busy | done |
           (|noc_rx_data) | (|noc_rx_addr) | (|tpc_start_pc) | (|err_code) |
           (|instr_count) | (|run_cycles);
  endfunction

  task automatic load_prog(input int n, input logic [7:0] last_op);
    logic [7:0] ops [0:3];
    ops[0] = OP_TENSOR; ops[1] = OP_TENSOR; ops[2] = OP_VECTOR; ops[3] = OP_SYNC;
    for (int i = 0; i < n; i++)
      prog[i] = {(i == n - 1) ? last_op : ops[i % 4], 8'(i),
                 112'h0123_4567_89AB_CDEF_0011_2233_4455 ^ 112'(i * 32'h1357)};
  endtask

  task automatic pulse_go(input logic le, input logic [19:0] pc);
    go = 1'b1; load_en = le; base_pc = pc;
    tick();
    go = 1'b0; load_en = 1'b0; base_pc = '0;
  endtask

  task automatic send_stream(input string tag, input int n);
    int  idx = 0;
    int  guard = 0;
    logic fire;
    while (idx < n && guard < 400) begin
      s_valid = 1'b1;
      s_data  = prog[idx];
      s_last  = (idx == n - 1);
      @(negedge clk);
      fire = s_ready;
      tick();
      if (fire) idx++;
      guard++;
    end
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    check({tag, "_stream"}, 64'(idx), 64'(n));
  endtask

  task automatic check_writes(input string tag, input int n, input logic [19:0] base);
    int bad = 0;
    check({tag, "_wcount"}, 64'(wa.size()), 64'(n));
    for (int i = 0; i < n && i < wa.size(); i++)
      if (wa[i] !== base + 20'(i) || wd[i] !== prog[i]) bad++;
    check({tag, "_worder"}, 64'(bad), 64'd0);
    check({tag, "_wfmt"}, 64'(fmt_err), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; go = 1'b0; load_en = 1'b0; base_pc = '0;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    noc_rx_ready = 1'b1; tpc_busy = 1'b0; tpc_done = 1'b0; tpc_error = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 64'(outs_any()), 64'd0);
    rst = 1'b0;
    tick();

    // 12-word program with HALT, base 0, always-ready NoC
    clear_mon();
    load_prog(12, OP_HALT);
    pulse_go(1'b1, 20'd0);
    check("t1_busy", 64'(busy), 64'd1);
    send_stream("t1", 12);
    wait_for("t1_start_hi", 0, 1'b1, 20);
    check("t1_start_pc", 64'(tpc_start_pc), 64'd0);
    wait_for("t1_start_lo", 0, 1'b0, 10);
    repeat (50) tick();
    tpc_done = 1'b1;
    tick();
    tpc_done = 1'b0;
    check("t1_done", 64'(done), 64'd1);
    check("t1_err", 64'(err_code), 64'(ERR_OK));
    check("t1_icount", 64'(instr_count), 64'd12);
    check("t1_runcyc", 64'(run_cycles >= 16'd49 && run_cycles <= 16'd51), 64'd1);
    check("t1_start_cnt", 64'(start_cnt), 64'd2);
    check_writes("t1", 12, 20'd0);
    tick();
    check("t1_done_pulse", 64'(done_cnt), 64'd1);
    check("t1_idle", 64'(busy), 64'd0);

    // Same program, NoC ready toggling every cycle, base 16
    clear_mon();
    toggle_ready = 1'b1;
    pulse_go(1'b1, 20'd16);
    send_stream("t2", 12);
    wait_for("t2_start_hi", 0, 1'b1, 40);
    check("t2_start_pc", 64'(tpc_start_pc), 64'd16);
    wait_for("t2_start_lo", 0, 1'b0, 10);
    repeat (5) tick();
    tpc_done = 1'b1;
    tick();
    tpc_done = 1'b0;
    check("t2_done", 64'(done), 64'd1);
    check("t2_err", 64'(err_code), 64'(ERR_OK));
    check_writes("t2", 12, 20'd16);
    check("t2_stable", 64'(stable_err), 64'd0);
    toggle_ready = 1'b0;
    noc_rx_ready = 1'b1;
    tick();

    // Last opcode is SYNC: NO_HALT, no launch
    clear_mon();
    load_prog(4, OP_SYNC);
    pulse_go(1'b1, 20'd40);
    send_stream("t3", 4);
    wait_for("t3_done", 1, 1'b1, 20);
    check("t3_err", 64'(err_code), 64'(ERR_NO_HALT));
    tick();
    check("t3_err_held", 64'(err_code), 64'(ERR_NO_HALT));
    check("t3_no_start", 64'(start_cnt), 64'd0);
    check_writes("t3", 4, 20'd40);

    // base 250, 10 words: 6 writes then drain, IMEM_OVERFLOW
    clear_mon();
    load_prog(10, OP_HALT);
    pulse_go(1'b1, 20'd250);
    send_stream("t4", 10);
    wait_for("t4_done", 1, 1'b1, 20);
    check("t4_err", 64'(err_code), 64'(ERR_IMEM_OVERFLOW));
    tick();
    check("t4_no_start", 64'(start_cnt), 64'd0);
    check_writes("t4", 6, 20'd250);
    check("t4_idle", 64'(busy), 64'd0);

    // Direct launch, TPC never finishes: timeout after 64 RUN cycles; a go
    // pulse during RUN must be ignored
    clear_mon();
    pulse_go(1'b0, 20'h00123);
    wait_for("t5_start_hi", 0, 1'b1, 5);
    check("t5_start_pc", 64'(tpc_start_pc), 64'h123);
    wait_for("t5_start_lo", 0, 1'b0, 5);
    begin
      int n = 0;
      while (!done && n < 200) begin
        go = (n == 10); load_en = (n == 10);
        tick();
        n++;
      end
      go = 1'b0; load_en = 1'b0;
      check("t5_timeout_cycle", 64'(n), 64'd64);
    end
    check("t5_err", 64'(err_code), 64'(ERR_TIMEOUT));
    check("t5_runcyc", 64'(run_cycles), 64'd64);
    check("t5_icount", 64'(instr_count), 64'd0);
    check("t5_start_cnt", 64'(start_cnt), 64'd2);
    tick();

    // Reset in the middle of a stalled load
    clear_mon();
    load_prog(4, OP_HALT);
    pulse_go(1'b1, 20'd8);
    noc_rx_ready = 1'b0;
    s_valid = 1'b1; s_data = prog[0]; s_last = 1'b0;
    repeat (3) tick();
    check("t6_pre_valid", 64'(noc_rx_valid), 64'd1);
    check("t6_pre_icount", 64'(instr_count), 64'd1);
    rst = 1'b1;
    tick();
    check("t6_rst_outputs", 64'(outs_any()), 64'd0);
    rst = 1'b0; s_valid = 1'b0; s_data = '0; noc_rx_ready = 1'b1;
    tick();

    // tpc_error and tpc_done together: TPC_ERROR wins
    clear_mon();
    pulse_go(1'b0, 20'd0);
    wait_for("t7_start_hi", 0, 1'b1, 5);
    wait_for("t7_start_lo", 0, 1'b0, 5);
    repeat (3) tick();
    tpc_error = 1'b1; tpc_done = 1'b1;
    tick();
    tpc_error = 1'b0; tpc_done = 1'b0;
    check("t7_done", 64'(done), 64'd1);
    check("t7_err", 64'(err_code), 64'(ERR_TPC_ERROR));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tpc_program_loader.md
Name: tpc_program_loader

Overview:
- Upstream stage of tensor_processing_cluster: takes a host stream of 128-bit TPC instructions and writes them into the TPC instruction memory over the NoC receive port (noc_rx_is_instr=1).
- It then launches the TPC at a chosen PC and supervises completion, reporting done, error or timeout.
- Replaces the hierarchical instr_mem pokes that benches use today, so programs reach the TPC through the real datapath.

Parameters:
- SRAM_WIDTH, 256, NoC data width; the instruction occupies bits [127:0], upper bits are zero.
- INSTR_WIDTH, 128, instruction word width.
- IMEM_DEPTH, 256, number of TPC instruction slots; the load address must stay below this.
- TIMEOUT_CYCLES, 4096, maximum RUN cycles before a timeout is declared.
- CNT_W, 16, width of the count and cycle counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- go  in  1  one-cycle command pulse; ignored unless state is IDLE
- load_en  in  1  sampled with go; 0 skips LOAD and launches directly
- base_pc  in  20  first imem address to write; also the start PC
- s_valid  in  1  host instruction stream valid
- s_ready  out  1  host stream ready
- s_data  in  128  instruction word
- s_last  in  1  marks the final word of the program
- noc_rx_data  out  SRAM_WIDTH  {zeros, instruction}
- noc_rx_addr  out  20  imem address
- noc_rx_valid  out  1  NoC write valid
- noc_rx_ready  in  1  NoC write ready
- noc_rx_is_instr  out  1  high whenever noc_rx_valid is high
- tpc_start  out  1  launch strobe
- tpc_start_pc  out  20  launch PC
- tpc_busy, tpc_done, tpc_error  in  1 each  TPC status
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse on completion, success or failure
- err_code  out  3  0 OK, 1 TPC_ERROR, 2 TIMEOUT, 3 NO_HALT, 4 IMEM_OVERFLOW; held until the next go
- instr_count  out  CNT_W  words accepted in the last load
- run_cycles  out  CNT_W  cycles spent in RUN, saturating

Behaviour:
- Reset: every output is 0; state is IDLE; buffer is empty.
- States:
  - IDLE: go with load_en=1 goes to LOAD; go with load_en=0 goes to START. On go, clear err_code and the counters and latch base_pc.
  - LOAD: one-entry output register. s_ready = !buf_valid || noc_rx_ready, so zero-bubble streaming is allowed.
    - Accepted word: noc_rx_addr = base_pc + instr_count, noc_rx_valid=1; the word holds until noc_rx_ready.
    - Accepted word with s_last: record whether s_data[127:120]==8'hFF.
    - Transition to START once the last word's NoC handshake completes.
  - START: tpc_start=1 for exactly 2 cycles with tpc_start_pc=latched base_pc, then go to RUN.
  - RUN: run_cycles increments each cycle.
    - tpc_done goes to DONE(OK).
    - tpc_error goes to DONE(TPC_ERROR). If tpc_error and tpc_done arrive in the same cycle, TPC_ERROR wins.
    - run_cycles==TIMEOUT_CYCLES-1 without done goes to DONE(TIMEOUT).
  - DONE: pulse done for 1 cycle, then go to IDLE.
- Overflow: accepting a word whose address is >= IMEM_DEPTH sets IMEM_OVERFLOW. That word is not forwarded. s_ready is held 1 and later words are drained and discarded up to s_last, then the loader goes to DONE without launching.
- NO_HALT: if the last word's opcode is not 0xFF, go to DONE(NO_HALT) after the final write and do not launch.
- s_last on the very first word is legal (single HALT program).
- go while busy is ignored; no state change.
- rst mid-operation returns to IDLE within one cycle and drops noc_rx_valid and tpc_start immediately. Partially loaded imem contents are left as-is.
- Latency: a word accepted in cycle N has noc_rx_valid=1 in cycle N+1.

Decomposition:
- Shared package tpc_pkg:
  - opcode constants: OP_TENSOR 0x01, OP_VECTOR 0x02, OP_SYNC 0x04, OP_HALT 0xFF;
  - err_code enum;
  - loader state enum.
- One natural sub-module: tpc_loader_skid, the one-entry valid/ready register stage. The FSM and counters stay in the top.

Test Plan:
- 12-word GEMM/VPU program ending in HALT, base_pc=0, noc_rx_ready=1:
  - 12 writes to addresses 0..11, with noc_rx_is_instr=1 on every write;
  - tpc_start high 2 cycles with pc=0;
  - tpc_done driven 50 cycles later -> done pulse, err_code=0, instr_count=12, run_cycles=50±1.
- Same program with noc_rx_ready toggling 1/0 every cycle -> every word is written once, in order, with no drops or duplicates; data is stable while valid && !ready.
- Last word opcode 0x04 -> err_code=3, tpc_start never asserted.
- base_pc=250 with a 10-word stream -> 6 writes to 250..255, remaining words drained, err_code=4, no launch.
- load_en=0, TPC never reports done, TIMEOUT_CYCLES=64 -> done at RUN cycle 64, err_code=2.
- Separate cases:
  - rst asserted mid-LOAD -> all outputs 0 next cycle;
  - tpc_error and tpc_done in the same cycle -> err_code=1.
